// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of a single-cycle core. Owns the PC, fetches one instruction
// word per instruction over a req/ack handshake with instruction memory, and
// holds that word for the decoder until the core signals advance. On advance
// the next PC is either pc_plus4 or the redirect target (pc_src). A target
// that is not 4-byte aligned parks the unit in a sticky FAULT state that only
// reset clears.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   imem_req / imem_addr    fetch request and address (address == pc)
//   imem_ack / imem_rdata   memory response, consumed only while requesting
//   instr / instr_valid     held instruction and its valid flag
//   pc / pc_plus4           address of instr and its sequential successor
//   advance                 core retires instr this cycle
//   pc_src / pc_target      redirect select and target
//   misalign_fault          sticky misaligned-redirect flag
//   retired_count           instructions retired since reset (wraps)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]           NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            advance,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            misalign_fault,
    output logic [31:0]     retired_count
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   next_pc_s;

    assign pc_plus4_s = pc_q + PC_STEP;
    assign next_pc_s  = pc_src ? pc_target : pc_plus4_s;

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;

        case (state_q)
            ST_FETCH: begin
                // req_q is low for the first cycle after reset, so an ack
                // there is not ours and is ignored.
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_EXEC;
                end else begin
                    req_d   = 1'b1;
                end
            end

            ST_EXEC: begin
                req_d = 1'b0;
                if (advance) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    // Only a redirect can be misaligned; pc_plus4 never is
                    // because pc itself is always aligned.
                    if (next_pc_s[1:0] == 2'b00) begin
                        pc_d    = next_pc_s;
                        instr_d = NOP_INSTR;
                        req_d   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end

            default: begin
                // Unreachable encoding: fail safe into the fault state.
                req_d   = 1'b0;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
                state_d = ST_FAULT;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_s;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign misalign_fault = fault_q;
    assign retired_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. Inputs change on the falling edge,
// outputs are sampled on the falling edge (half a cycle after the active
// edge). A second instance with RESET_PC = 0xFFFF_FFFC covers PC wrap.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;

    logic        imem_req, imem_ack, instr_valid, advance, pc_src, misalign_fault;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, pc_target, retired_count;

    logic        imem_req2, imem_ack2, instr_valid2, advance2, pc_src2, misalign_fault2;
    logic [31:0] imem_addr2, imem_rdata2, instr2, pc2, pc_plus42, pc_target2, retired_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .advance(advance), .pc_src(pc_src), .pc_target(pc_target),
        .misalign_fault(misalign_fault), .retired_count(retired_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .instr(instr2), .instr_valid(instr_valid2),
        .pc(pc2), .pc_plus4(pc_plus42),
        .advance(advance2), .pc_src(pc_src2), .pc_target(pc_target2),
        .misalign_fault(misalign_fault2), .retired_count(retired_count2)
    );

    // Stimulus helper: clear inputs, pulse reset, return at the falling edge
    // right after release (req is still low there).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'd0; advance = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
        imem_ack2 = 1'b0; imem_rdata2 = 32'd0; advance2 = 1'b0; pc_src2 = 1'b0; pc_target2 = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Stimulus helper: acknowledge a fetch with word w for one cycle.
    task automatic give_ack(input logic [31:0] w);
        imem_ack = 1'b1; imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    // Stimulus helper: one-cycle advance with the given redirect inputs.
    task automatic give_adv(input logic src, input logic [31:0] tgt);
        advance = 1'b1; pc_src = src; pc_target = tgt;
        @(negedge clk);
        advance = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req_after_release got=%0b exp=0", imem_req); end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req_rises got=%0b exp=1", imem_req); end
        // Reset mid-FETCH with req high: req must drop without a clock edge.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_async_req got=%0b exp=0", imem_req); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (pc !== 32'd0 || imem_addr !== 32'd0) begin
            failures++; $display("FAIL reset_pc got pc=%h addr=%h exp=0", pc, imem_addr);
        end
        checks++;
        if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL reset_instr got instr=%h valid=%0b exp=00000013/0", instr, instr_valid);
        end
        checks++;
        if (misalign_fault !== 1'b0 || retired_count !== 32'd0) begin
            failures++; $display("FAIL reset_flags got fault=%0b count=%0d exp=0/0", misalign_fault, retired_count);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h0050_0093; words[1] = 32'h0010_8113; words[2] = 32'h0021_01B3;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                failures++; $display("FAIL seq_fetch%0d got req=%0b addr=%h exp=1/%h", i, imem_req, imem_addr, 4 * i);
            end
            give_ack(words[i]);
            checks++;
            if (instr_valid !== 1'b1 || instr !== words[i] || imem_req !== 1'b0 || pc !== 32'(4 * i)) begin
                failures++; $display("FAIL seq_exec%0d got valid=%0b instr=%h req=%0b pc=%h exp=1/%h/0/%h",
                                     i, instr_valid, instr, imem_req, pc, words[i], 4 * i);
            end
            give_adv(1'b0, 32'd0);
            checks++;
            if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
                failures++; $display("FAIL seq_retire%0d got valid=%0b instr=%h exp=0/00000013", i, instr_valid, instr);
            end
        end
        checks++;
        if (retired_count !== 32'd3 || pc !== 32'd12) begin
            failures++; $display("FAIL seq_count got count=%0d pc=%h exp=3/0000000c", retired_count, pc);
        end
    endtask

    task automatic test_wait_states();
        int bad = 0;
        do_reset();
        @(negedge clk);
        advance = 1'b1; pc_src = 1'b1; pc_target = 32'h80;
        for (int i = 0; i < 5; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wait_stable got bad_cycles=%0d exp=0", bad); end
        advance = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
        checks++;
        if (retired_count !== 32'd0 || pc !== 32'd0) begin
            failures++; $display("FAIL wait_adv_ignored got count=%0d pc=%h exp=0/0", retired_count, pc);
        end
        give_ack(32'hDEAD_BEEF);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wait_ack got valid=%0b instr=%h exp=1/deadbeef", instr_valid, instr);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            give_ack(32'h0000_0013);
            give_adv(1'b0, 32'd0);
        end
        give_ack(32'h0400_0063);
        pc_src = 1'b1; pc_target = 32'h40;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pc !== 32'h10 || instr_valid !== 1'b1 || imem_req !== 1'b0 || retired_count !== 32'd4) begin
            failures++; $display("FAIL branch_no_adv got pc=%h valid=%0b req=%0b count=%0d exp=10/1/0/4",
                                 pc, instr_valid, imem_req, retired_count);
        end
        checks++;
        if (pc_plus4 !== 32'h14) begin failures++; $display("FAIL branch_plus4 got=%h exp=14", pc_plus4); end
        give_adv(1'b1, 32'h40);
        checks++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1 || retired_count !== 32'd5) begin
            failures++; $display("FAIL branch_taken got addr=%h req=%0b count=%0d exp=40/1/5",
                                 imem_addr, imem_req, retired_count);
        end
    endtask

    task automatic test_misaligned();
        int bad = 0;
        do_reset();
        @(negedge clk);
        give_ack(32'h0420_006F);
        give_adv(1'b1, 32'h42);
        checks++;
        if (misalign_fault !== 1'b1 || pc !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL mis_fault got fault=%0b pc=%h valid=%0b req=%0b exp=1/0/0/0",
                                 misalign_fault, pc, instr_valid, imem_req);
        end
        checks++;
        if (retired_count !== 32'd1) begin failures++; $display("FAIL mis_count got=%0d exp=1", retired_count); end
        imem_ack = 1'b1; pc_src = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance = i[0];
            @(negedge clk);
            if (imem_req !== 1'b0 || misalign_fault !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'd0) bad++;
        end
        imem_ack = 1'b0; advance = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mis_sticky got bad_cycles=%0d exp=0", bad); end
        do_reset();
        checks++;
        if (misalign_fault !== 1'b0 || retired_count !== 32'd0) begin
            failures++; $display("FAIL mis_reset got fault=%0b count=%0d exp=0/0", misalign_fault, retired_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++;
        if (pc2 !== 32'hFFFF_FFFC || pc_plus42 !== 32'd0) begin
            failures++; $display("FAIL wrap_plus4 got pc=%h plus4=%h exp=fffffffc/0", pc2, pc_plus42);
        end
        @(negedge clk);
        imem_ack2 = 1'b1; imem_rdata2 = 32'h0000_0013;
        @(negedge clk);
        imem_ack2 = 1'b0;
        advance2 = 1'b1; pc_src2 = 1'b0;
        @(negedge clk);
        advance2 = 1'b0;
        checks++;
        if (imem_addr2 !== 32'd0 || imem_req2 !== 1'b1 || misalign_fault2 !== 1'b0) begin
            failures++; $display("FAIL wrap_next got addr=%h req=%0b fault=%0b exp=0/1/0",
                                 imem_addr2, imem_req2, misalign_fault2);
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'd0; advance = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
        imem_ack2 = 1'b0; imem_rdata2 = 32'd0; advance2 = 1'b0; pc_src2 = 1'b0; pc_target2 = 32'd0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_misaligned();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
